// File: rtl/calculator_pkg.sv
// Shared types and constants for the calculator sequencing logic.
package calculator_pkg;

    typedef enum logic [1:0] {
        S_ENTRY_A = 2'd0,
        S_OP      = 2'd1,
        S_ENTRY_B = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam int SLIDER_N = 4;

endpackage

// File: rtl/calculator_edge_detect.sv
// Rising-edge detector for one debounced button level; history resets to 1 so a
// button already held when reset releases does not count as a press.
module calculator_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic press_o
);

    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 1'b1;
        else        hist_q <= level_i;
    end

    assign press_o = level_i & ~hist_q;

endmodule

// File: rtl/calculator_control.sv
// Calculator sequencing FSM: captures two 4-bit operands, applies add/sub with
// carry/borrow, supports chaining from the last result, and registers the display.
module calculator_control
    import calculator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_clr,
    input  logic             button_ent,
    input  logic             button_add,
    input  logic             button_sub,
    input  logic             slider_1,
    input  logic             slider_2,
    input  logic             slider_3,
    input  logic             slider_4,
    output logic [WIDTH-1:0] display,
    output logic [1:0]       state_code,
    output logic             op_is_sub,
    output logic             overflow,
    output logic             result_valid
);

    logic press_clr, press_ent, press_add, press_sub;
    logic clr_p, ent_p, add_p, sub_p;

    calculator_edge_detect u_ed_clr (.clk(clk), .rst_n(reset), .level_i(button_clr), .press_o(press_clr));
    calculator_edge_detect u_ed_ent (.clk(clk), .rst_n(reset), .level_i(button_ent), .press_o(press_ent));
    calculator_edge_detect u_ed_add (.clk(clk), .rst_n(reset), .level_i(button_add), .press_o(press_add));
    calculator_edge_detect u_ed_sub (.clk(clk), .rst_n(reset), .level_i(button_sub), .press_o(press_sub));

    // Only the highest-priority press in a cycle survives: clr > ent > add > sub.
    assign clr_p = press_clr;
    assign ent_p = press_ent & ~press_clr;
    assign add_p = press_add & ~press_clr & ~press_ent;
    assign sub_p = press_sub & ~press_clr & ~press_ent & ~press_add;

    logic [SLIDER_N-1:0] slider_nib;
    logic [WIDTH-1:0]    slider_val;
    assign slider_nib = {slider_4, slider_3, slider_2, slider_1};
    assign slider_val = WIDTH'(slider_nib);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic             valid_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;

    assign sum  = {1'b0, opa_q} + {1'b0, slider_val};
    assign diff = opa_q - slider_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ENTRY_A;
            op_q    <= OP_ADD;
            opa_q   <= '0;
            res_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            res_q   <= res_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            valid_q <= (state_d == S_RESULT);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        if (clr_p) begin
            state_d = S_ENTRY_A;
            op_d    = OP_ADD;
            opa_d   = '0;
            res_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_ENTRY_A: begin
                    if (ent_p) begin
                        opa_d   = slider_val;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (add_p) begin
                        op_d    = OP_ADD;
                        state_d = S_ENTRY_B;
                    end else if (sub_p) begin
                        op_d    = OP_SUB;
                        state_d = S_ENTRY_B;
                    end
                end
                S_ENTRY_B: begin
                    if (ent_p) begin
                        if (op_q == OP_SUB) begin
                            res_d = diff;
                            ovf_d = (opa_q < slider_val);
                        end else begin
                            res_d = sum[WIDTH-1:0];
                            ovf_d = sum[WIDTH];
                        end
                        state_d = S_RESULT;
                    end else if (add_p) begin
                        op_d = OP_ADD;
                    end else if (sub_p) begin
                        op_d = OP_SUB;
                    end
                end
                S_RESULT: begin
                    // Chain: last result becomes the first operand of the next op.
                    if (add_p || sub_p) begin
                        opa_d   = res_q;
                        op_d    = sub_p ? OP_SUB : OP_ADD;
                        ovf_d   = 1'b0;
                        state_d = S_ENTRY_B;
                    end
                end
                default: state_d = S_ENTRY_A;
            endcase
        end
    end

    always_comb begin
        disp_d = slider_val;
        unique case (state_d)
            S_OP:     disp_d = opa_d;
            S_RESULT: disp_d = res_d;
            default:  disp_d = slider_val;
        endcase
    end

    assign display      = disp_q;
    assign state_code   = state_q;
    assign op_is_sub    = (op_q == OP_SUB);
    assign overflow     = ovf_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_calculator_control.sv
// Directed bench for calculator_control: one 8-bit and one 4-bit instance share stimulus.
module tb_calculator_control;

    logic clk = 1'b0;
    logic reset;
    logic bclr, bent, badd, bsub;
    logic s1, s2, s3, s4;

    logic [7:0] disp8;
    logic [1:0] st8;
    logic       sub8, ovf8, val8;
    logic [3:0] disp4;
    logic [1:0] st4;
    logic       sub4, ovf4, val4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calculator_control #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset),
        .button_clr(bclr), .button_ent(bent), .button_add(badd), .button_sub(bsub),
        .slider_1(s1), .slider_2(s2), .slider_3(s3), .slider_4(s4),
        .display(disp8), .state_code(st8), .op_is_sub(sub8),
        .overflow(ovf8), .result_valid(val8)
    );

    calculator_control #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset),
        .button_clr(bclr), .button_ent(bent), .button_add(badd), .button_sub(bsub),
        .slider_1(s1), .slider_2(s2), .slider_3(s3), .slider_4(s4),
        .display(disp4), .state_code(st4), .op_is_sub(sub4),
        .overflow(ovf4), .result_valid(val4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sl(input logic [3:0] v);
        {s4, s3, s2, s1} = v;
    endtask

    // mask = {clr, ent, add, sub}; one-cycle pulse then release
    task automatic press(input logic [3:0] mask);
        {bclr, bent, badd, bsub} = mask;
        tick();
        {bclr, bent, badd, bsub} = 4'b0000;
        tick();
    endtask

    localparam logic [3:0] CLR = 4'b1000, ENT = 4'b0100, ADD = 4'b0010, SUB = 4'b0001;

    initial begin
        reset = 1'b1;
        {bclr, bent, badd, bsub} = 4'b0000;
        set_sl(4'd0);
        #2 reset = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            {bclr, bent, badd, bsub} = 4'($urandom_range(0, 15));
            set_sl(4'($urandom_range(0, 15)));
            tick();
        end
        chk("rst_display", 32'(disp8), 32'h0);
        chk("rst_state",   32'(st8),   32'h0);
        chk("rst_ovf",     32'(ovf8),  32'h0);
        chk("rst_valid",   32'(val8),  32'h0);
        {bclr, bent, badd, bsub} = 4'b0000;
        set_sl(4'd0);
        reset = 1'b1;
        tick();
        tick();

        // 5 + 3
        set_sl(4'd5);
        press(ENT);
        chk("a_state",   32'(st8),   32'd1);
        chk("a_display", 32'(disp8), 32'd5);
        press(ADD);
        chk("op_state",  32'(st8),   32'd2);
        set_sl(4'd3);
        press(ENT);
        tick();
        chk("add_display", 32'(disp8), 32'd8);
        chk("add_ovf",     32'(ovf8),  32'd0);
        chk("add_state",   32'(st8),   32'd3);
        chk("add_valid",   32'(val8),  32'd1);

        // 3 - 5 wraps to 0xFE with borrow
        press(CLR);
        chk("clr_state",   32'(st8),   32'd0);
        chk("clr_display", 32'(disp8), 32'd3);
        press(ENT);
        press(SUB);
        set_sl(4'd5);
        press(ENT);
        tick();
        chk("sub_display", 32'(disp8), 32'hFE);
        chk("sub_ovf",     32'(ovf8),  32'd1);
        chk("sub_opsub",   32'(sub8),  32'd1);

        // 4-bit: 15 + 1 wraps with carry, then chain + 2
        press(CLR);
        set_sl(4'd15);
        press(ENT);
        press(ADD);
        set_sl(4'd1);
        press(ENT);
        chk("w4_display", 32'(disp4), 32'd0);
        chk("w4_ovf",     32'(ovf4),  32'd1);
        chk("w4_state",   32'(st4),   32'd3);
        press(ADD);
        chk("w4_chain_state", 32'(st4),  32'd2);
        chk("w4_chain_ovf",   32'(ovf4), 32'd0);
        set_sl(4'd2);
        press(ENT);
        chk("w4_chain_display", 32'(disp4), 32'd2);
        chk("w4_chain_ovf2",    32'(ovf4),  32'd0);

        // clr and ent together in S_ENTRY_B: clr wins
        press(CLR);
        set_sl(4'd7);
        press(ENT);
        press(ADD);
        set_sl(4'd9);
        press(CLR | ENT);
        chk("pri_state",   32'(st8),   32'd0);
        chk("pri_display", 32'(disp8), 32'd9);
        chk("pri_valid",   32'(val8),  32'd0);

        // ent held 20 cycles: one capture only
        set_sl(4'd6);
        bent = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("hold_state",   32'(st8),   32'd1);
        chk("hold_display", 32'(disp8), 32'd6);
        set_sl(4'd2);
        tick();
        chk("hold_nocap", 32'(disp8), 32'd6);
        bent = 1'b0;
        tick();

        // Async reset mid-cycle in S_ENTRY_B with operand_a = 7
        press(CLR);
        set_sl(4'd7);
        press(ENT);
        press(ADD);
        chk("pre_rst_state", 32'(st8), 32'd2);
        @(posedge clk);
        #3;
        bent  = 1'b1;
        reset = 1'b0;
        #1;
        chk("async_display", 32'(disp8), 32'd0);
        chk("async_state",   32'(st8),   32'd0);
        chk("async_valid",   32'(val8),  32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("held_release_state",   32'(st8),   32'd0);
        chk("held_release_display", 32'(disp8), 32'd7);
        bent = 1'b0;
        tick();
        press(ENT);
        chk("post_rst_ent_state", 32'(st8), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
